// File: rtl/ddr3_axi_traffic_gen_pkg.sv
// Shared types and helpers for the DDR3 AXI traffic generator.
// The pattern function is the single source for write data and read expectations.
package ddr3_tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_AW = 3'd1,
    S_WR_W  = 3'd2,
    S_WR_B  = 3'd3,
    S_RD_AR = 3'd4,
    S_RD_R  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [31:0] tg_pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ddr3_axi_traffic_gen_if.sv
// AXI4 bus between the traffic generator (master) and the ddr3_axi inport (slave).
interface ddr3_axi_traffic_gen_if;

  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awready;

  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wready;

  logic        bready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arready;

  logic        rready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    output bready, input bvalid, bresp, bid,
    output arvalid, araddr, arid, arlen, arburst, input arready,
    output rready, input rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    input bready, output bvalid, bresp, bid,
    input arvalid, araddr, arid, arlen, arburst, output arready,
    input rready, output rvalid, rdata, rresp, rid, rlast
  );

endinterface

// File: rtl/ddr3_axi_traffic_gen.sv
// AXI4 memory self-test initiator: writes NUM_BURSTS INCR bursts of a seeded pattern,
// reads them back and counts mismatching or errored beats, with a per-handshake watchdog.
module ddr3_axi_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned NUM_BURSTS = 16,
  parameter logic [7:0]  BURST_LEN  = 8'd7,
  parameter logic [3:0]  AXI_ID     = 4'h3,
  parameter logic [31:0] SEED       = 32'hA5A5_0000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  ddr3_axi_traffic_gen_if.master outport
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_WR_AW = S_WR_AW;
  localparam logic [2:0] ST_WR_W  = S_WR_W;
  localparam logic [2:0] ST_WR_B  = S_WR_B;
  localparam logic [2:0] ST_RD_AR = S_RD_AR;
  localparam logic [2:0] ST_RD_R  = S_RD_R;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam logic [31:0] BURST_BYTES = ({24'd0, BURST_LEN} + 32'd1) << 2;
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
  localparam logic [31:0] WDOG_LIMIT  = 32'(TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [15:0] burst_reg, burst_next;
  logic [7:0]  beat_reg, beat_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdog_reg, wdog_next;
  logic [15:0] err_reg, err_next;
  logic [31:0] ferr_addr_reg, ferr_addr_next;
  logic        ferr_valid_reg, ferr_valid_next;
  logic        timeout_reg, timeout_next;

  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any;
  logic        busy, beat_is_last, last_burst, b_err, r_err;
  logic [31:0] beat_addr, exp_data, err_addr;
  logic [7:0]  r_missing;
  logic [8:0]  err_inc;
  logic [16:0] err_sum;

  assign aw_hs  = outport.awvalid & outport.awready;
  assign w_hs   = outport.wvalid & outport.wready;
  assign b_hs   = outport.bvalid & outport.bready;
  assign ar_hs  = outport.arvalid & outport.arready;
  assign r_hs   = outport.rvalid & outport.rready;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign beat_is_last = (beat_reg == BURST_LEN);
  assign last_burst   = (burst_reg == LAST_BURST);
  assign beat_addr    = addr_reg + {22'd0, beat_reg, 2'b00};
  assign exp_data     = tg_pattern(beat_addr, SEED);

  assign b_err = (outport.bresp != AXI_RESP_OKAY) || (outport.bid != AXI_ID);
  assign r_err = (outport.rdata != exp_data) || (outport.rresp != AXI_RESP_OKAY) ||
                 (outport.rid != AXI_ID) || (outport.rlast != beat_is_last);
  // An early rlast closes the burst; every beat never delivered is charged as an error.
  assign r_missing = (outport.rlast && !beat_is_last) ? (BURST_LEN - beat_reg) : 8'd0;

  always_comb begin
    state_next      = state_reg;
    burst_next      = burst_reg;
    beat_next       = beat_reg;
    addr_next       = addr_reg;
    wdog_next       = wdog_reg;
    err_next        = err_reg;
    ferr_addr_next  = ferr_addr_reg;
    ferr_valid_next = ferr_valid_reg;
    timeout_next    = timeout_reg;
    err_inc         = 9'd0;
    err_addr        = beat_addr;
    err_sum         = 17'd0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_next      = ST_WR_AW;
          burst_next      = 16'd0;
          beat_next       = 8'd0;
          addr_next       = ADDR_BASE;
          wdog_next       = 32'd0;
          err_next        = 16'd0;
          ferr_addr_next  = 32'd0;
          ferr_valid_next = 1'b0;
          timeout_next    = 1'b0;
        end
      end
      ST_WR_AW: begin
        if (aw_hs) begin
          state_next = ST_WR_W;
          beat_next  = 8'd0;
        end
      end
      ST_WR_W: begin
        if (w_hs) begin
          if (beat_is_last) state_next = ST_WR_B;
          else              beat_next  = beat_reg + 8'd1;
        end
      end
      ST_WR_B: begin
        if (b_hs) begin
          err_addr = addr_reg;
          err_inc  = {8'd0, b_err};
          if (last_burst) begin
            state_next = ST_RD_AR;
            burst_next = 16'd0;
            addr_next  = ADDR_BASE;
          end else begin
            state_next = ST_WR_AW;
            burst_next = burst_reg + 16'd1;
            addr_next  = addr_reg + BURST_BYTES;
          end
        end
      end
      ST_RD_AR: begin
        if (ar_hs) begin
          state_next = ST_RD_R;
          beat_next  = 8'd0;
        end
      end
      ST_RD_R: begin
        if (r_hs) begin
          err_inc = {8'd0, r_err} + {1'b0, r_missing};
          // A missing rlast on the final beat is an error but still closes the burst.
          if (outport.rlast || beat_is_last) begin
            if (last_burst) begin
              state_next = ST_DONE;
            end else begin
              state_next = ST_RD_AR;
              burst_next = burst_reg + 16'd1;
              addr_next  = addr_reg + BURST_BYTES;
            end
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    err_sum = {1'b0, err_reg} + {8'd0, err_inc};
    if (err_inc != 9'd0) begin
      err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (!ferr_valid_reg) begin
        ferr_addr_next  = err_addr;
        ferr_valid_next = 1'b1;
      end
    end

    // Watchdog only fires on a cycle with no handshake, so no error update is lost.
    if (busy) begin
      if (hs_any) begin
        wdog_next = 32'd0;
      end else if (wdog_reg == WDOG_LIMIT) begin
        state_next   = ST_DONE;
        timeout_next = 1'b1;
        wdog_next    = 32'd0;
      end else begin
        wdog_next = wdog_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      burst_reg      <= 16'd0;
      beat_reg       <= 8'd0;
      addr_reg       <= 32'd0;
      wdog_reg       <= 32'd0;
      err_reg        <= 16'd0;
      ferr_addr_reg  <= 32'd0;
      ferr_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      burst_reg      <= burst_next;
      beat_reg       <= beat_next;
      addr_reg       <= addr_next;
      wdog_reg       <= wdog_next;
      err_reg        <= err_next;
      ferr_addr_reg  <= ferr_addr_next;
      ferr_valid_reg <= ferr_valid_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Valids decode straight from state, so payload registers only move after a handshake.
  assign outport.awvalid = (state_reg == ST_WR_AW);
  assign outport.awaddr  = addr_reg;
  assign outport.awid    = AXI_ID;
  assign outport.awlen   = BURST_LEN;
  assign outport.awburst = AXI_BURST_INCR;

  assign outport.wvalid  = (state_reg == ST_WR_W);
  assign outport.wdata   = exp_data;
  assign outport.wstrb   = 4'hF;
  assign outport.wlast   = beat_is_last;

  assign outport.bready  = (state_reg == ST_WR_B);

  assign outport.arvalid = (state_reg == ST_RD_AR);
  assign outport.araddr  = addr_reg;
  assign outport.arid    = AXI_ID;
  assign outport.arlen   = BURST_LEN;
  assign outport.arburst = AXI_BURST_INCR;

  assign outport.rready  = (state_reg == ST_RD_R);

  assign busy_o           = busy;
  assign done_o           = (state_reg == ST_DONE);
  assign pass_o           = done_o && (err_reg == 16'd0) && !timeout_reg;
  assign timeout_o        = timeout_reg;
  assign err_count_o      = err_reg;
  assign first_err_addr_o = ferr_addr_reg;

endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// Directed bench: memory-backed AXI slave BFM with optional stalls and fault injection.
module tb_ddr3_axi_traffic_gen;

  localparam int BL = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;

  ddr3_axi_traffic_gen_if bus ();

  ddr3_axi_traffic_gen #(
    .ADDR_BASE (32'h0000_0100),
    .NUM_BURSTS(2),
    .BURST_LEN (8'd3),
    .AXI_ID    (4'h3),
    .SEED      (32'hA5A5_0000),
    .TIMEOUT   (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .pass_o          (pass_o),
    .timeout_o       (timeout_o),
    .err_count_o     (err_count_o),
    .first_err_addr_o(first_err_addr_o),
    .outport         (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // BFM configuration (written only by the test sequence)
  bit stall_en = 0, aw_block = 0, corrupt_en = 0, bresp_err_en = 0;

  // BFM state and logs (written only by the BFM process)
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  logic        wlast_log[$];
  int          r_cnt = 0, viol = 0;
  bit          armed[5];
  int          wait_cnt[5];
  logic [31:0] w_addr, b_addr, r_addr;
  int          w_beat, b_todo, r_beat;
  bit          r_busy;
  logic        p_aw_hs, p_w_hs, p_b_hs, p_ar_hs, p_r_hs;
  logic        p_awvalid, p_wvalid, p_arvalid, p_bvalid, p_rvalid, p_wlast;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  task automatic pick(input int ch, input logic v, output logic r);
    if (!v) begin
      r = 1'b0;
      armed[ch] = 1'b0;
    end else if (!stall_en) begin
      r = 1'b1;
    end else begin
      if (!armed[ch]) begin
        armed[ch] = 1'b1;
        wait_cnt[ch] = int'($urandom_range(0, 5));
      end
      if (wait_cnt[ch] == 0) begin
        r = 1'b1;
        armed[ch] = 1'b0;
      end else begin
        r = 1'b0;
        wait_cnt[ch]--;
      end
    end
  endtask

  task automatic bfm_clear();
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rid = 0; bus.rlast = 0;
    for (int i = 0; i < 5; i++) begin armed[i] = 0; wait_cnt[i] = 0; end
    w_addr = 0; b_addr = 0; r_addr = 0; w_beat = 0; b_todo = 0; r_beat = 0; r_busy = 0;
    p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
    p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bvalid = 0; p_rvalid = 0; p_wlast = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
  endtask

  // Slave BFM: on each falling edge, retire the handshakes of the last rising edge,
  // check master stability, then drive the response side for the next rising edge.
  initial begin
    logic        r;
    logic [31:0] a;
    bfm_clear();
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bfm_clear();
        continue;
      end
      if (p_aw_hs) begin
        aw_log.push_back(p_awaddr);
        w_addr = p_awaddr;
        w_beat = 0;
        $display("AW addr=%08h", p_awaddr);
      end
      if (p_w_hs) begin
        mem[w_addr + 32'(4 * w_beat)] = p_wdata;
        w_log.push_back(p_wdata);
        wlast_log.push_back(p_wlast);
        w_beat++;
        if (p_wlast) begin b_todo++; b_addr = w_addr; end
      end
      if (p_b_hs) begin
        b_todo--;
        $display("B  addr=%08h resp=%0d", b_addr, bus.bresp);
      end
      if (p_ar_hs) begin
        ar_log.push_back(p_araddr);
        r_addr = p_araddr;
        r_beat = 0;
        r_busy = 1;
        $display("AR addr=%08h", p_araddr);
      end
      if (p_r_hs) begin
        r_cnt++;
        r_beat++;
        if (r_beat > BL) r_busy = 0;
      end
      if (p_awvalid && !p_aw_hs && (bus.awvalid !== 1'b1 || bus.awaddr !== p_awaddr)) viol++;
      if (p_wvalid && !p_w_hs && (bus.wvalid !== 1'b1 || bus.wdata !== p_wdata ||
                                  bus.wlast !== p_wlast)) viol++;
      if (p_arvalid && !p_ar_hs && (bus.arvalid !== 1'b1 || bus.araddr !== p_araddr)) viol++;

      if (aw_block) bus.awready = 1'b0;
      else begin pick(0, bus.awvalid, r); bus.awready = r; end
      pick(1, bus.wvalid, r);  bus.wready = r;
      pick(2, bus.arvalid, r); bus.arready = r;
      if (!(p_bvalid && !p_b_hs)) begin
        pick(3, b_todo > 0, r);
        bus.bvalid = r;
        bus.bresp = (bresp_err_en && b_addr == 32'h100) ? 2'b10 : 2'b00;
        bus.bid = 4'h3;
      end
      if (!(p_rvalid && !p_r_hs)) begin
        pick(4, r_busy, r);
        bus.rvalid = r;
        a = r_addr + 32'(4 * r_beat);
        bus.rdata = mem.exists(a) ? mem[a] : 32'd0;
        if (corrupt_en && r_addr == 32'h110 && r_beat == 2) bus.rdata = bus.rdata ^ 32'd1;
        bus.rlast = (r_beat == BL);
        bus.rresp = 2'b00;
        bus.rid = 4'h3;
      end

      p_aw_hs = bus.awvalid & bus.awready;
      p_w_hs  = bus.wvalid & bus.wready;
      p_b_hs  = bus.bvalid & bus.bready;
      p_ar_hs = bus.arvalid & bus.arready;
      p_r_hs  = bus.rvalid & bus.rready;
      p_awvalid = bus.awvalid; p_awaddr = bus.awaddr;
      p_wvalid = bus.wvalid; p_wdata = bus.wdata; p_wlast = bus.wlast;
      p_arvalid = bus.arvalid; p_araddr = bus.araddr;
      p_bvalid = bus.bvalid; p_rvalid = bus.rvalid;
    end
  end

  task automatic start_pass();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done_o === 1'b1) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (!ok) begin $display("FAIL %s_wait_done got=timeout want=done_o", name); bad++; end
    total++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      $display("FAIL reset_valids got=%05b want=00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}); bad++;
    end
    total++;
    if ({busy_o, done_o, pass_o, timeout_o} !== 4'b0) begin
      $display("FAIL reset_status got=%04b want=0000", {busy_o, done_o, pass_o, timeout_o}); bad++;
    end
    total++;
    if (err_count_o !== 16'd0 || first_err_addr_o !== 32'd0) begin
      $display("FAIL reset_err got=%0d/%08h want=0/00000000", err_count_o, first_err_addr_o); bad++;
    end
    total++;
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    int aw0 = aw_log.size(), w0 = w_log.size(), ar0 = ar_log.size(), r0 = r_cnt;
    logic [31:0] exp_w [8] = '{32'hA5A5_0100, 32'hA5A5_0104, 32'hA5A5_0108, 32'hA5A5_010C,
                               32'hA5A5_0110, 32'hA5A5_0114, 32'hA5A5_0118, 32'hA5A5_011C};
    logic [7:0] lasts;
    start_pass();
    if (bus.awvalid !== 1'b1 || busy_o !== 1'b1) begin
      $display("FAIL basic_latency got=awvalid%0b busy%0b want=1/1", bus.awvalid, busy_o); bad++;
    end
    total++;
    if ({bus.awaddr, bus.awid, bus.awlen, bus.awburst} !== {32'h100, 4'h3, 8'd3, 2'b01}) begin
      $display("FAIL basic_aw_fields got=%08h/%0h/%0d/%0d want=00000100/3/3/1",
               bus.awaddr, bus.awid, bus.awlen, bus.awburst); bad++;
    end
    total++;
    wait_done("basic");
    if (pass_o !== 1'b1 || err_count_o !== 16'd0 || timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL basic_result got=pass%0b err%0d to%0b busy%0b want=1/0/0/0",
               pass_o, err_count_o, timeout_o, busy_o); bad++;
    end
    total++;
    if (aw_log.size() - aw0 != 2 || aw_log[aw0] !== 32'h100 || aw_log[aw0+1] !== 32'h110) begin
      $display("FAIL basic_aw_addrs got=%0d bursts want=2 at 00000100,00000110", aw_log.size() - aw0);
      bad++;
    end
    total++;
    if (w_log.size() - w0 != 8) begin
      $display("FAIL basic_w_count got=%0d want=8", w_log.size() - w0); bad++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_log[w0+i] !== exp_w[i]) begin
          $display("FAIL basic_wdata[%0d] got=%08h want=%08h", i, w_log[w0+i], exp_w[i]); bad++;
        end
        total++;
      end
      for (int i = 0; i < 8; i++) lasts[i] = wlast_log[w0+i];
      if (lasts !== 8'b1000_1000) begin
        $display("FAIL basic_wlast got=%08b want=10001000", lasts); bad++;
      end
      total++;
    end
    total++;
    if (ar_log.size() - ar0 != 2 || ar_log[ar0] !== 32'h100 || ar_log[ar0+1] !== 32'h110) begin
      $display("FAIL basic_ar_addrs got=%0d bursts want=2 at 00000100,00000110", ar_log.size() - ar0);
      bad++;
    end
    total++;
    if (r_cnt - r0 != 8 || bus.wstrb !== 4'hF) begin
      $display("FAIL basic_r_count got=%0d/strb%0h want=8/f", r_cnt - r0, bus.wstrb); bad++;
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int aw0 = aw_log.size();
    start_pass();
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("FAIL b2b_restart got=done%0b busy%0b want=0/1", done_o, busy_o); bad++;
    end
    total++;
    wait_done("b2b");
    if (pass_o !== 1'b1 || aw_log.size() - aw0 != 2) begin
      $display("FAIL b2b_result got=pass%0b aw%0d want=1/2", pass_o, aw_log.size() - aw0); bad++;
    end
    total++;
  endtask

  task automatic test_stall();
    int v0 = viol, w0 = w_log.size(), r0 = r_cnt;
    stall_en = 1;
    start_pass();
    wait_done("stall");
    if (viol - v0 != 0) begin
      $display("FAIL stall_stability got=%0d changes want=0", viol - v0); bad++;
    end
    total++;
    if (pass_o !== 1'b1 || err_count_o !== 16'd0 || w_log.size() - w0 != 8 || r_cnt - r0 != 8) begin
      $display("FAIL stall_result got=pass%0b err%0d w%0d r%0d want=1/0/8/8",
               pass_o, err_count_o, w_log.size() - w0, r_cnt - r0); bad++;
    end
    total++;
    stall_en = 0;
  endtask

  task automatic test_corrupt();
    corrupt_en = 1;
    start_pass();
    wait_done("corrupt");
    if (err_count_o !== 16'd1 || first_err_addr_o !== 32'h118) begin
      $display("FAIL corrupt_err got=%0d/%08h want=1/00000118", err_count_o, first_err_addr_o); bad++;
    end
    total++;
    if (pass_o !== 1'b0 || timeout_o !== 1'b0) begin
      $display("FAIL corrupt_pass got=pass%0b to%0b want=0/0", pass_o, timeout_o); bad++;
    end
    total++;
    corrupt_en = 0;
  endtask

  task automatic test_bresp();
    bresp_err_en = 1;
    start_pass();
    wait_done("bresp");
    if (err_count_o !== 16'd1 || first_err_addr_o !== 32'h100 || pass_o !== 1'b0) begin
      $display("FAIL bresp_err got=%0d/%08h pass%0b want=1/00000100/0",
               err_count_o, first_err_addr_o, pass_o); bad++;
    end
    total++;
    bresp_err_en = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    aw_block = 1;
    start_pass();
    while (bus.awvalid === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (n != 16) begin
      $display("FAIL timeout_cycles got=%0d want=16", n); bad++;
    end
    total++;
    if ({timeout_o, done_o, pass_o, busy_o} !== 4'b1100) begin
      $display("FAIL timeout_status got=%04b want=1100", {timeout_o, done_o, pass_o, busy_o}); bad++;
    end
    total++;
    aw_block = 0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    start_pass();
    for (int i = 0; i < 200; i++) begin
      if (bus.rready === 1'b1) begin seen = 1; break; end
      @(negedge clk_i);
    end
    if (!seen) begin $display("FAIL rstmid_reach_rd got=no rready want=rready"); bad++; end
    total++;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, busy_o, done_o, pass_o,
         timeout_o} !== 9'b0 || err_count_o !== 16'd0 || first_err_addr_o !== 32'd0) begin
      $display("FAIL rstmid_outputs got=rready%0b busy%0b done%0b err%0d want=all 0",
               bus.rready, busy_o, done_o, err_count_o); bad++;
    end
    total++;
    rst_ni = 1'b1;
    @(negedge clk_i);
    start_pass();
    wait_done("rstmid");
    if (pass_o !== 1'b1 || err_count_o !== 16'd0) begin
      $display("FAIL rstmid_newpass got=pass%0b err%0d want=1/0", pass_o, err_count_o); bad++;
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_corrupt();
    test_bresp();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time got=still running want=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
